// File: rtl/branch_resolve_ex.sv
// branch_resolve_ex: ID/EX register with flag-based branch resolution, Fetch redirect and taken-branch counter
module branch_resolve_ex #(
  parameter int IW = 17,
  parameter int AW = 12,
  parameter int CW = 16,
  parameter logic [4:0] OP_B   = 5'h10,
  parameter logic [4:0] OP_BEQ = 5'h11,
  parameter logic [4:0] OP_BNE = 5'h12,
  parameter logic [4:0] OP_BLT = 5'h13,
  parameter logic [4:0] OP_BL  = 5'h14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] InstrD,
  input  logic [AW-1:0] PCD,
  input  logic [AW-1:0] PCPlus1D,
  input  logic          StallD,
  input  logic          FlagWE,
  input  logic          ZeroIn,
  input  logic          NegIn,
  output logic          PCSrcE,
  output logic [AW-1:0] PCTargetE,
  output logic          FlushD,
  output logic          ValidE,
  output logic [IW-1:0] InstrE,
  output logic [AW-1:0] PCE,
  output logic          LinkWE,
  output logic [AW-1:0] PCPlus1E,
  output logic [CW-1:0] TakenCnt
);
  logic       z, n, taken;
  logic [4:0] op;
  assign op = InstrE[IW-1:IW-5];
  always_comb begin
    taken = ValidE & ((op == OP_B) | (op == OP_BL) | ((op == OP_BEQ) & z) |
                      ((op == OP_BNE) & ~z) | ((op == OP_BLT) & n));
  end
  assign PCSrcE    = taken;
  assign FlushD    = taken;
  assign PCTargetE = InstrE[AW-1:0];
  assign LinkWE    = ValidE & (op == OP_BL);
  // A taken branch turns the wrong-path D instruction into a bubble, overriding any stall
  always_ff @(posedge clk) begin
    if (reset || taken) begin
      ValidE   <= 1'b0;
      InstrE   <= '0;
      PCE      <= '0;
      PCPlus1E <= '0;
    end else if (!StallD) begin
      ValidE   <= 1'b1;
      InstrE   <= InstrD;
      PCE      <= PCD;
      PCPlus1E <= PCPlus1D;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      z <= 1'b0;
      n <= 1'b0;
    end else if (FlagWE) begin
      z <= ZeroIn;
      n <= NegIn;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) TakenCnt <= '0;
    else if (taken) TakenCnt <= TakenCnt + 1'b1;
  end
endmodule
